// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - commit-stream checker against golden INUM records
// Reports the first divergence between retired instructions and the golden stream.
module trace_checker #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             commit_valid,
   input  logic [15:0]      c_pc,
   input  logic             c_reg_we,
   input  logic [2:0]       c_reg,
   input  logic [15:0]      c_reg_val,
   input  logic             c_mem_rd,
   input  logic             c_mem_wr,
   input  logic [15:0]      c_addr,
   input  logic [15:0]      c_mdata,
   input  logic             c_halt,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [85:0]      exp_rec,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [10:0]      err_mask,
   output logic [CNT_W-1:0] err_inum,
   output logic [CNT_W-1:0] inst_count
);

   localparam int IW = $clog2(TIMEOUT);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_FAIL = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idle_cnt;

   logic [15:0] e_pc, e_reg_val, e_addr, e_mdata;
   logic [2:0]  e_reg;
   logic        e_reg_we, e_mem_rd, e_mem_wr, e_halt;

   assign e_pc      = exp_rec[85:70];
   assign e_reg_we  = exp_rec[69];
   assign e_reg     = exp_rec[68:66];
   assign e_reg_val = exp_rec[65:50];
   assign e_mem_rd  = exp_rec[49];
   assign e_mem_wr  = exp_rec[48];
   assign e_addr    = exp_rec[47:32];
   assign e_mdata   = exp_rec[31:16];
   assign e_halt    = exp_rec[15];

   logic        run;
   logic        timeout_hit;
   logic [8:0]  cmp_mask;
   logic        fail_set;
   logic        accept;
   logic [10:0] fail_code;

   assign run         = (state == S_RUN);
   assign exp_ready   = run & commit_valid & exp_valid;
   assign timeout_hit = run & ~commit_valid & (idle_cnt == IW'(TIMEOUT - 1));

   // Optional fields are only checked when the golden record says they carry meaning.
   always_comb begin
      cmp_mask    = '0;
      cmp_mask[0] = (c_pc != e_pc);
      cmp_mask[1] = (c_reg_we != e_reg_we);
      cmp_mask[2] = e_reg_we & (c_reg != e_reg);
      cmp_mask[3] = e_reg_we & (c_reg_val != e_reg_val);
      cmp_mask[4] = (c_mem_rd != e_mem_rd);
      cmp_mask[5] = (c_mem_wr != e_mem_wr);
      cmp_mask[6] = (e_mem_rd | e_mem_wr) & (c_addr != e_addr);
      cmp_mask[7] = e_mem_wr & (c_mdata != e_mdata);
      cmp_mask[8] = (c_halt != e_halt);
   end

   always_comb begin
      fail_set  = 1'b0;
      accept    = 1'b0;
      fail_code = '0;
      if (run) begin
         if (commit_valid) begin
            if (!exp_valid) begin
               fail_set  = 1'b1;
               fail_code = 11'h200;
            end else if (|cmp_mask) begin
               fail_set  = 1'b1;
               fail_code = {2'b00, cmp_mask};
            end else begin
               accept = 1'b1;
            end
         end else if (timeout_hit) begin
            fail_set  = 1'b1;
            fail_code = 11'h400;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_RUN;
         idle_cnt   <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         err_mask   <= '0;
         err_inum   <= '0;
         inst_count <= '0;
      end else if (run) begin
         idle_cnt <= commit_valid ? '0 : idle_cnt + 1'b1;
         if (fail_set) begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            done     <= 1'b1;
            err_mask <= fail_code;
            err_inum <= inst_count;
         end else if (accept) begin
            if (inst_count != '1)
               inst_count <= inst_count + 1'b1;
            if (e_halt) begin
               state <= S_PASS;
               pass  <= 1'b1;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - randomized self-checking bench for trace_checker
// Reference model works on whole records and absolute cycle numbers.
module tb_trace_checker;

   localparam int TO   = 16;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct packed {
      logic [15:0] pc;
      logic        reg_we;
      logic [2:0]  rg;
      logic [15:0] reg_val;
      logic        mem_rd;
      logic        mem_wr;
      logic [15:0] addr;
      logic [15:0] mdata;
      logic        halt;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          commit_valid = 1'b0;
   logic [15:0]   c_pc = '0;
   logic          c_reg_we = 1'b0;
   logic [2:0]    c_reg = '0;
   logic [15:0]   c_reg_val = '0;
   logic          c_mem_rd = 1'b0;
   logic          c_mem_wr = 1'b0;
   logic [15:0]   c_addr = '0;
   logic [15:0]   c_mdata = '0;
   logic          c_halt = 1'b0;
   logic          exp_valid = 1'b0;
   logic          exp_ready;
   logic [85:0]   exp_rec = '0;
   logic          done, pass, fail;
   logic [10:0]   err_mask;
   logic [CW-1:0] err_inum, inst_count;

   trace_checker #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid),
      .c_pc(c_pc), .c_reg_we(c_reg_we), .c_reg(c_reg), .c_reg_val(c_reg_val),
      .c_mem_rd(c_mem_rd), .c_mem_wr(c_mem_wr), .c_addr(c_addr), .c_mdata(c_mdata),
      .c_halt(c_halt), .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rec(exp_rec),
      .done(done), .pass(pass), .fail(fail), .err_mask(err_mask),
      .err_inum(err_inum), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // model: 0 running, 1 passed, 2 failed
   int m_st, m_mask, m_inum, m_cnt, m_cyc, m_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
      end
   endtask

   function automatic rec_t mk(input logic [15:0] pc, input logic we, input logic [2:0] rg,
                               input logic [15:0] val, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] md, input logic halt);
      rec_t r;
      r.pc = pc; r.reg_we = we; r.rg = rg; r.reg_val = val; r.mem_rd = rd;
      r.mem_wr = wr; r.addr = addr; r.mdata = md; r.halt = halt;
      return r;
   endfunction

   function automatic int ref_mask(input rec_t c, input rec_t e);
      int m = 0;
      if (c.pc != e.pc) m += 1;
      if (c.reg_we != e.reg_we) m += 2;
      if (e.reg_we && c.rg != e.rg) m += 4;
      if (e.reg_we && c.reg_val != e.reg_val) m += 8;
      if (c.mem_rd != e.mem_rd) m += 16;
      if (c.mem_wr != e.mem_wr) m += 32;
      if ((e.mem_rd || e.mem_wr) && c.addr != e.addr) m += 64;
      if (e.mem_wr && c.mdata != e.mdata) m += 128;
      if (c.halt != e.halt) m += 256;
      return m;
   endfunction

   task automatic m_fail(input int code);
      m_st = 2; m_mask = code; m_inum = m_cnt;
   endtask

   task automatic model_edge(input bit cv, input rec_t c, input bit ev, input rec_t e);
      int mk_v;
      m_cyc++;
      if (m_st == 0) begin
         if (cv) begin
            m_last = m_cyc;
            if (!ev) m_fail(32'h200);
            else begin
               mk_v = ref_mask(c, e);
               if (mk_v != 0) m_fail(mk_v);
               else begin
                  if (m_cnt < MAXC) m_cnt++;
                  if (e.halt) m_st = 1;
               end
            end
         end else if (m_cyc - m_last == TO) begin
            m_fail(32'h400);
         end
      end
   endtask

   task automatic check_outputs();
      check("done", done, m_st != 0);
      check("pass", pass, m_st == 1);
      check("fail", fail, m_st == 2);
      check("err_mask", err_mask, m_mask);
      check("err_inum", err_inum, m_inum);
      check("inst_count", inst_count, m_cnt);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit cv, input rec_t c, input bit ev, input rec_t e);
      commit_valid = cv;
      c_pc = c.pc; c_reg_we = c.reg_we; c_reg = c.rg; c_reg_val = c.reg_val;
      c_mem_rd = c.mem_rd; c_mem_wr = c.mem_wr; c_addr = c.addr; c_mdata = c.mdata;
      c_halt = c.halt;
      exp_valid = ev;
      exp_rec = {e, 15'($urandom)};
      #1;
      check("exp_ready", exp_ready, (m_st == 0) && cv && ev);
      if (exp_ready) pulses++;
      @(posedge clk);
      model_edge(cv, c, ev, e);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      rec_t z = '0;
      for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, z);
   endtask

   task automatic match(input rec_t r);
      step(1'b1, r, 1'b1, r);
   endtask

   task automatic do_reset();
      rec_t z = '0;
      commit_valid = 1'b0; exp_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", fail, 0);
      check("rst_mask", err_mask, 0);
      check("rst_inum", err_inum, 0);
      check("rst_count", inst_count, 0);
      check("rst_ready", exp_ready, 0);
      #3 rst_n = 1'b1;
      m_st = 0; m_mask = 0; m_inum = 0; m_cnt = 0; m_cyc = 0; m_last = 0;
      @(posedge clk);
      model_edge(1'b0, z, 1'b0, z);
      @(negedge clk);
      check_outputs();
   endtask

   function automatic rec_t rand_rec(input logic halt);
      rec_t r;
      r = rec_t'({$urandom, $urandom, $urandom});
      r.halt = halt;
      return r;
   endfunction

   function automatic rec_t corrupt(input rec_t r);
      rec_t c = r;
      case ($urandom_range(0, 8))
         0: c.pc[$urandom_range(0, 15)] ^= 1'b1;
         1: c.reg_we ^= 1'b1;
         2: c.rg ^= 3'($urandom_range(1, 7));
         3: c.reg_val[$urandom_range(0, 15)] ^= 1'b1;
         4: c.mem_rd ^= 1'b1;
         5: c.mem_wr ^= 1'b1;
         6: c.addr[$urandom_range(0, 15)] ^= 1'b1;
         7: c.mdata[$urandom_range(0, 15)] ^= 1'b1;
         default: c.halt ^= 1'b1;
      endcase
      return c;
   endfunction

   rec_t prog [5];
   rec_t c, e;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);

      // matched stream ending in halt
      do_reset();
      prog[0] = mk(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
      prog[1] = mk(16'h0002, 0, 3'd0, 16'h0000, 0, 1, 16'h0040, 16'hBEEF, 0);
      prog[2] = mk(16'h0004, 1, 3'd2, 16'h1234, 1, 0, 16'h0040, 16'h0000, 0);
      prog[3] = mk(16'h0006, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
      prog[4] = mk(16'h0008, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
      pulses = 0;
      for (int i = 0; i < 5; i++) match(prog[i]);
      check("halt_pass", pass, 1);
      check("halt_done", done, 1);
      check("halt_count", inst_count, 5);
      match(prog[0]);
      check("halt_pulses", pulses, 5);

      // register value mismatch at INUM 2
      do_reset();
      match(prog[0]); match(prog[1]);
      c = prog[2]; c.reg_val = 16'h1235;
      step(1'b1, c, 1'b1, prog[2]);
      check("rv_mask", err_mask, 11'h008);
      check("rv_inum", err_inum, 2);
      check("rv_count", inst_count, 2);
      match(prog[3]);

      // store mismatch on addr and mdata
      do_reset();
      c = prog[1]; c.addr = 16'h0042; c.mdata = 16'hBEEE;
      step(1'b1, c, 1'b1, prog[1]);
      check("st_mask", err_mask, 11'h0C0);

      // reg_val ignored when no register write is expected
      do_reset();
      c = prog[3]; c.reg_val = 16'hDEAD; c.rg = 3'd5;
      step(1'b1, c, 1'b1, prog[3]);
      check("mask_nofail", fail, 0);
      check("mask_count", inst_count, 1);

      // underflow at INUM 3
      do_reset();
      for (int i = 0; i < 3; i++) match(prog[i]);
      step(1'b1, prog[3], 1'b0, prog[3]);
      check("uf_mask", err_mask, 11'h200);
      check("uf_inum", err_inum, 3);

      // timeout fires 16 cycles after the last commit
      do_reset();
      match(prog[0]);
      idle(TO - 1);
      check("to_early", fail, 0);
      idle(1);
      check("to_fail", fail, 1);
      check("to_mask", err_mask, 11'h400);

      // commit in the 15th idle cycle, and in the last possible cycle
      do_reset();
      match(prog[0]);
      idle(TO - 2);
      match(prog[1]);
      idle(TO - 1);
      match(prog[2]);
      idle(TO - 2);
      check("to_saved", fail, 0);
      check("to_saved_count", inst_count, 3);

      // asynchronous reset mid-run, then INUM restarts at 0
      do_reset();
      for (int i = 0; i < 3; i++) match(prog[i]);
      check("mid_count", inst_count, 3);
      do_reset();
      c = prog[0]; c.pc = 16'h0010;
      step(1'b1, c, 1'b1, prog[0]);
      check("mid_inum", err_inum, 0);
      check("mid_mask", err_mask, 11'h001);

      // randomized streams, long enough to saturate the counters
      for (int t = 0; t < 40; t++) begin
         int len;
         do_reset();
         len = $urandom_range(1, 22);
         for (int i = 0; i < len; i++) begin
            e = rand_rec((i == len - 1) && ($urandom_range(0, 1) == 1));
            c = ($urandom_range(0, 5) == 0) ? corrupt(e) : e;
            for (int g = $urandom_range(0, 3); g > 0; g--)
               step(1'b0, e, 1'($urandom_range(0, 1)), e);
            if ($urandom_range(0, 14) == 0) step(1'b1, c, 1'b0, e);
            else step(1'b1, c, 1'b1, e);
         end
         idle(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
